bank_burst_master: RTL and testbench

Descriptor-driven burst master that sits directly upstream of the bank RAM subsystem and occupies one of its master slots. It turns a single (write/read, start bank, start address, length) descriptor into a sequence of single-word bank commands interleaved across banks. For writes it forwards an input data stream; for reads it collects in-order responses into an output stream. Read commands are credit-limited so a response always has buffer space.

---
 rtl/bank_burst_pkg.sv | 30 +++
 rtl/bank_rsp_fifo.sv | 54 +++++
 rtl/bank_burst_master.sv | 162 ++++++++++++++++
 tb/tb_bank_burst_master.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bank_burst_pkg.sv
// Shared types for the bank burst master: FSM states, bank-index width helper
// and the descriptor layout presented on the desc_* ports.
package bank_burst_pkg;

    localparam int NUM_BANKS_DEF  = 5;
    localparam int ADDR_WIDTH_DEF = 9;
    localparam int LEN_WIDTH_DEF  = 12;

    function automatic int bank_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int BANK_W_DEF = bank_width(NUM_BANKS_DEF);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic                      write;
        logic [BANK_W_DEF-1:0]     bank;
        logic [ADDR_WIDTH_DEF-1:0] addr;
        logic [LEN_WIDTH_DEF-1:0]  len;
    } desc_t;

endpackage

// File: rtl/bank_rsp_fifo.sv
// Read-response FIFO: power-of-two depth, storage-backed head word, push and
// pop in the same cycle allowed even when full or empty.
module bank_rsp_fifo #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32,
    localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  full,
    output logic                  empty,
    output logic [CNT_W-1:0]      count
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop frees the slot the push needs, so a full FIFO still accepts.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/bank_burst_master.sv
// Descriptor-driven burst master: splits a burst into single-word bank commands
// interleaved across banks, with credit-limited reads feeding a response FIFO.
module bank_burst_master
    import bank_burst_pkg::*;
#(
    parameter int NUM_BANKS       = 5,
    parameter int ADDR_WIDTH      = 9,
    parameter int DATA_WIDTH      = 32,
    parameter int LEN_WIDTH       = 12,
    parameter int MAX_OUTSTANDING = 4,
    localparam int BANK_W         = bank_width(NUM_BANKS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  desc_valid,
    output logic                  desc_ready,
    input  logic                  desc_write,
    input  logic [BANK_W-1:0]     desc_bank,
    input  logic [ADDR_WIDTH-1:0] desc_addr,
    input  logic [LEN_WIDTH-1:0]  desc_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic                  cmd_we,
    output logic [BANK_W-1:0]     cmd_bank,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    output logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic                  rsp_valid,
    input  logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  busy,
    output logic                  done
);

    localparam int CRED_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);

    state_t                state;
    state_t                state_next;
    desc_t                 desc_in;
    logic [BANK_W-1:0]     bank_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  remaining;
    logic [CRED_W-1:0]     credits;
    logic                  load;
    logic                  last_word;
    logic                  cmd_fire;
    logic                  read_issue;
    logic                  rd_fire;
    logic                  rsp_expected;
    logic                  rsp_push;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CRED_W-1:0]     fifo_count;

    assign desc_in = '{write: desc_write, bank: desc_bank, addr: desc_addr, len: desc_len};

    assign last_word  = (remaining == LEN_WIDTH'(1));
    assign cmd_fire   = cmd_valid & cmd_ready;
    assign read_issue = cmd_fire & (state == READ);
    assign rd_fire    = rd_valid & rd_ready;

    assign cmd_bank  = bank_q;
    assign cmd_addr  = addr_q;
    assign cmd_wdata = wr_data;
    assign busy      = (state != IDLE);

    always_comb begin
        state_next = state;
        desc_ready = 1'b0;
        wr_ready   = 1'b0;
        cmd_valid  = 1'b0;
        cmd_we     = 1'b0;
        load       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                desc_ready = 1'b1;
                if (desc_valid) begin
                    load = 1'b1;
                    if (desc_in.len == '0) state_next = DONE;
                    else                   state_next = desc_in.write ? WRITE : READ;
                end
            end
            WRITE: begin
                cmd_valid = wr_valid;
                wr_ready  = cmd_ready;
                cmd_we    = 1'b1;
                if (wr_valid && cmd_ready && last_word) state_next = DONE;
            end
            READ: begin
                // Only issue when a FIFO slot is guaranteed for the response.
                cmd_valid = (credits < CRED_W'(MAX_OUTSTANDING));
                if (cmd_valid && cmd_ready && last_word) state_next = DRAIN;
            end
            DRAIN: begin
                if (credits == '0) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bank_q    <= '0;
            addr_q    <= '0;
            remaining <= '0;
            credits   <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                bank_q    <= desc_in.bank;
                addr_q    <= desc_in.addr;
                remaining <= desc_in.len;
            end else if (cmd_fire) begin
                remaining <= remaining - LEN_WIDTH'(1);
                if (bank_q == LAST_BANK) begin
                    bank_q <= '0;
                    addr_q <= addr_q + ADDR_WIDTH'(1);
                end else begin
                    bank_q <= bank_q + BANK_W'(1);
                end
            end
            case ({read_issue, rd_fire})
                2'b10:   credits <= credits + CRED_W'(1);
                2'b01:   credits <= credits - CRED_W'(1);
                default: credits <= credits;
            endcase
        end
    end

    // Credits cover words both in flight and buffered; a response is only
    // legitimate while some credit is not yet backed by a FIFO entry.
    assign rsp_expected = (credits > fifo_count);
    assign rsp_push     = rsp_valid & rsp_expected & (~fifo_full | rd_fire);
    assign rd_valid     = ~fifo_empty;

    bank_rsp_fifo #(
        .DEPTH      (MAX_OUTSTANDING),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rsp_push),
        .push_data (rsp_rdata),
        .pop       (rd_fire),
        .pop_data  (rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_bank_burst_master.sv
// Scoreboard bench for bank_burst_master: directed bursts with hand-listed
// command sequences, a 2-cycle-latency RAM response model and a pop-and-compare monitor.
module tb_bank_burst_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        desc_valid = 1'b0;
    logic        desc_ready;
    logic        desc_write = 1'b0;
    logic [2:0]  desc_bank = '0;
    logic [8:0]  desc_addr = '0;
    logic [11:0] desc_len = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] wr_data = '0;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [31:0] rd_data;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic        cmd_we;
    logic [2:0]  cmd_bank;
    logic [8:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_rdata = '0;
    logic        busy;
    logic        done;

    bank_burst_master dut (
        .clk(clk), .rst(rst),
        .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_write(desc_write),
        .desc_bank(desc_bank), .desc_addr(desc_addr), .desc_len(desc_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_bank(cmd_bank), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  bank;
        logic [8:0]  addr;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    cmd_t        exp_cmd_q[$];
    logic [31:0] exp_rd_q[$];
    logic [31:0] wr_q[$];
    rsp_t        rsp_q[$];

    int passed_cnt = 0;
    int total_cnt  = 0;
    int cyc = 0;
    int outstanding = 0;
    int cmd_cnt = 0;
    int rd_cmd_cnt = 0;
    int done_cnt = 0;
    int last_cmd_cyc = 0;
    int last_rd_cyc = 0;
    int desc_cyc = 0;
    int done_cyc = 0;
    bit stall = 1'b0;
    bit rd_hold = 1'b0;

    function automatic logic [31:0] mem_word(input logic [2:0] b, input logic [8:0] a);
        return 32'hA500_0000 | (32'(b) << 12) | 32'(a);
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) passed_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    // Stimulus driver and RAM response model, updated just after each rising edge.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
            rsp_valid = 1'b1;
            rsp_rdata = rsp_q[0].data;
            void'(rsp_q.pop_front());
        end else begin
            rsp_valid = 1'b0;
        end
        cmd_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        rd_ready  = rd_hold ? 1'b0 : (stall ? 1'($urandom_range(0, 1)) : 1'b1);
        wr_valid  = (wr_q.size() > 0) && (stall ? 1'($urandom_range(0, 1)) : 1'b1);
        wr_data   = (wr_q.size() > 0) ? wr_q[0] : 32'h0;
    end

    // Monitor: pops the scoreboard whenever the DUT completes a handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (rd_valid && rd_ready) begin
                if (exp_rd_q.size() == 0) check("rd_unexpected", 1, 0);
                else check("rd_data", rd_data, exp_rd_q.pop_front());
                outstanding--;
                last_rd_cyc = cyc;
            end
            if (cmd_valid && cmd_ready) begin
                cmd_t e;
                cmd_cnt++;
                last_cmd_cyc = cyc;
                if (exp_cmd_q.size() == 0) begin
                    check("cmd_unexpected", 1, 0);
                end else begin
                    e = exp_cmd_q.pop_front();
                    check("cmd_we", 32'(cmd_we), 32'(e.we));
                    check("cmd_bank", 32'(cmd_bank), 32'(e.bank));
                    check("cmd_addr", 32'(cmd_addr), 32'(e.addr));
                    if (e.we) check("cmd_wdata", cmd_wdata, e.wdata);
                end
                if (cmd_we) begin
                    if (wr_valid && wr_ready && wr_q.size() > 0) void'(wr_q.pop_front());
                end else begin
                    rd_cmd_cnt++;
                    outstanding++;
                    check("credit_limit", 32'(outstanding <= 4), 1);
                    rsp_q.push_back('{due: cyc + 2, data: mem_word(cmd_bank, cmd_addr)});
                end
            end
            if (desc_valid && desc_ready) desc_cyc = cyc;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic expect_cmd(input bit we, input int b, input int a, input logic [31:0] d);
        exp_cmd_q.push_back('{we: we, bank: 3'(b), addr: 9'(a), wdata: d});
        if (we) wr_q.push_back(d);
        else exp_rd_q.push_back(mem_word(3'(b), 9'(a)));
    endtask

    task automatic send_desc(input bit w, input int b, input int a, input int len);
        int n = 0;
        @(posedge clk); #1;
        desc_valid = 1'b1;
        desc_write = w;
        desc_bank  = 3'(b);
        desc_addr  = 9'(a);
        desc_len   = 12'(len);
        do begin
            @(negedge clk); #1;
            n++;
        end while (!desc_ready && n < 100);
        check("desc_accept", 32'(desc_ready), 1);
        @(posedge clk); #1;
        desc_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int kind);
        int n = 0;
        int base = done_cnt;
        while (done_cnt == base && n < 400) begin
            @(negedge clk); #1;
            n++;
        end
        check({name, "_done_seen"}, 32'(done_cnt > base), 1);
        if (kind == 0) check({name, "_done_cyc"}, 32'(done_cyc), 32'(last_cmd_cyc + 1));
        if (kind == 1) check({name, "_done_cyc"}, 32'(done_cyc), 32'(last_rd_cyc + 2));
        if (kind == 2) check({name, "_done_cyc"}, 32'(done_cyc), 32'(desc_cyc + 1));
        check({name, "_cmd_left"}, 32'(exp_cmd_q.size()), 0);
        check({name, "_rd_left"}, 32'(exp_rd_q.size()), 0);
        @(negedge clk); #1;
        check({name, "_ready_after"}, 32'(desc_ready), 1);
        check({name, "_idle_after"}, 32'(busy), 0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_desc_ready"}, 32'(desc_ready), 1);
        check({name, "_cmd_valid"}, 32'(cmd_valid), 0);
        check({name, "_wr_ready"}, 32'(wr_ready), 0);
        check({name, "_rd_valid"}, 32'(rd_valid), 0);
        check({name, "_busy"}, 32'(busy), 0);
        check({name, "_done"}, 32'(done), 0);
        check({name, "_cmd_bank"}, 32'(cmd_bank), 0);
        check({name, "_cmd_addr"}, 32'(cmd_addr), 0);
    endtask

    initial begin
        int base;
        int b_r10 [10] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4};
        int a_r10 [10] = '{'h20, 'h20, 'h20, 'h20, 'h20, 'h21, 'h21, 'h21, 'h21, 'h21};
        int b_r8  [8]  = '{2, 3, 4, 0, 1, 2, 3, 4};
        int a_r8  [8]  = '{'h30, 'h30, 'h30, 'h31, 'h31, 'h31, 'h31, 'h31};
        int b_w12 [12] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1, 2};
        int a_w12 [12] = '{'h50, 'h50, 'h50, 'h50, 'h51, 'h51, 'h51, 'h51, 'h51, 'h52, 'h52, 'h52};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk); #1;
        check_reset_outputs("reset");

        // Write len 7 from bank 3, addr 0x10.
        expect_cmd(1, 3, 'h10, 32'h1000_0000);
        expect_cmd(1, 4, 'h10, 32'h1000_0001);
        expect_cmd(1, 0, 'h11, 32'h1000_0002);
        expect_cmd(1, 1, 'h11, 32'h1000_0003);
        expect_cmd(1, 2, 'h11, 32'h1000_0004);
        expect_cmd(1, 3, 'h11, 32'h1000_0005);
        expect_cmd(1, 4, 'h11, 32'h1000_0006);
        send_desc(1, 3, 'h10, 7);
        wait_done("wr7", 0);

        // Read len 10 from bank 0, addr 0x20.
        for (int i = 0; i < 10; i++) expect_cmd(0, b_r10[i], a_r10[i], 32'h0);
        send_desc(0, 0, 'h20, 10);
        wait_done("rd10", 1);

        // Read len 8 with the read stream held off: credits must cap issue at 4.
        rd_hold = 1'b1;
        base = rd_cmd_cnt;
        for (int i = 0; i < 8; i++) expect_cmd(0, b_r8[i], a_r8[i], 32'h0);
        send_desc(0, 2, 'h30, 8);
        repeat (15) @(negedge clk);
        #1;
        check("rd8_issued_held", 32'(rd_cmd_cnt - base), 4);
        check("rd8_cmd_valid_held", 32'(cmd_valid), 0);
        rd_hold = 1'b0;
        wait_done("rd8", 1);
        check("rd8_issued_total", 32'(rd_cmd_cnt - base), 8);

        // Address wrap at the top of the bank.
        expect_cmd(1, 4, 'h1FF, 32'hDEAD_0001);
        expect_cmd(1, 0, 'h000, 32'hDEAD_0002);
        send_desc(1, 4, 'h1FF, 2);
        wait_done("wrap", 0);

        // Empty burst.
        base = cmd_cnt;
        send_desc(1, 1, 'h40, 0);
        wait_done("len0", 2);
        check("len0_no_cmd", 32'(cmd_cnt - base), 0);

        // Write len 12 under random stalls on both sides.
        stall = 1'b1;
        for (int i = 0; i < 12; i++) expect_cmd(1, b_w12[i], a_w12[i], 32'h5500_0000 + 32'(i));
        send_desc(1, 1, 'h50, 12);
        wait_done("wr12_stall", 0);

        // Read under stalls, abandoned by a reset mid-burst.
        for (int i = 0; i < 10; i++) expect_cmd(0, b_r10[i], a_r10[i] + 'h40, 32'h0);
        send_desc(0, 0, 'h60, 10);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_cmd_q.delete();
        exp_rd_q.delete();
        rsp_q.delete();
        wr_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        outstanding = 0;
        rsp_q.delete();
        stall = 1'b0;
        @(negedge clk); #1;
        check_reset_outputs("midreset");

        // Next descriptor after the reset: read crossing the address wrap.
        expect_cmd(0, 4, 'h1FF, 32'h0);
        expect_cmd(0, 0, 'h000, 32'h0);
        expect_cmd(0, 1, 'h000, 32'h0);
        send_desc(0, 4, 'h1FF, 3);
        wait_done("rd_after_rst", 1);

        $display("%0d/%0d checks passed", passed_cnt, total_cnt);
        $finish;
    end

endmodule
